// File: rtl/mem_resp_model.sv
// mem_resp_model: fixed-latency word memory responder with byte/halfword store merge and load extension.
// Define MEM_RESP_RANDLAT_EN to add 0..3 LFSR-driven extra cycles of latency per request.
module mem_resp_model #(
    parameter int          ADDR_WIDTH = 10,
    parameter int          LATENCY    = 4,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_req,
    input  logic        write_req,
    input  logic [31:0] addr,
    input  logic [1:0]  wr_ctrl,
    input  logic [2:0]  rd_ctrl,
    input  logic [31:0] wr_data,
    output logic        rd_data_valid,
    output logic        wr_ready,
    output logic [31:0] rd_data
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t                  state;
    logic [31:0]             mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0]   idx;
    logic [31:0]             rword, wword, rext, rd_buf;
    logic [7:0]              rbyte;
    logic [15:0]             rhalf;
    logic [4:0]              lat, cnt;
    logic                    is_rd, accept;
    logic                    unused_addr;
    assign idx         = addr[ADDR_WIDTH+1:2];
    assign unused_addr = ^addr[31:ADDR_WIDTH+2];
    assign rword       = mem[idx];
    assign rbyte       = rword[{addr[1:0], 3'b000} +: 8];
    assign rhalf       = rword[{addr[1], 4'b0000} +: 16];
    assign accept      = (state == IDLE) && (read_req || write_req);
    always_comb begin
        rext = rd_ctrl == 3'd1 ? {{24{rbyte[7]}}, rbyte} :
               rd_ctrl == 3'd2 ? {{16{rhalf[15]}}, rhalf} :
               rd_ctrl == 3'd4 ? {24'd0, rbyte} :
               rd_ctrl == 3'd5 ? {16'd0, rhalf} : rword;
    end
    always_comb begin
        wword = rword;
        if (wr_ctrl == 2'd1)
            wword[{addr[1:0], 3'b000} +: 8] = wr_data[7:0];
        else if (wr_ctrl == 2'd2)
            wword[{addr[1], 4'b0000} +: 16] = wr_data[15:0];
        else if (wr_ctrl == 2'd3)
            wword = wr_data;
    end
`ifdef MEM_RESP_RANDLAT_EN
    logic [7:0] lfsr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lfsr <= LFSR_SEED;
        else if (accept)
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
    assign lat = 5'(LATENCY) + {3'b000, lfsr[1:0]};
`else
    assign lat = 5'(LATENCY);
`endif
    // The array is written here but never cleared by rst; stores commit at acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= 5'd0;
            is_rd         <= 1'b0;
            rd_buf        <= 32'd0;
            rd_data       <= 32'd0;
            rd_data_valid <= 1'b0;
            wr_ready      <= 1'b0;
        end else begin
            rd_data_valid <= 1'b0;
            wr_ready      <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    is_rd  <= !write_req;
                    cnt    <= lat - 5'd1;
                    rd_buf <= rext;
                    if (write_req)
                        mem[idx] <= wword;
                    if (lat == 5'd1) begin
                        state         <= RESP;
                        rd_data_valid <= !write_req;
                        wr_ready      <= write_req;
                        if (!write_req)
                            rd_data <= rext;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: if (cnt == 5'd0) begin
                    state         <= RESP;
                    rd_data_valid <= is_rd;
                    wr_ready      <= !is_rd;
                    if (is_rd)
                        rd_data <= rd_buf;
                end else begin
                    cnt <= cnt - 5'd1;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
